// File: rtl/masked_sbox_compress_if.sv
`default_nettype none
// ============================================================================
// Module      : masked_sbox_compress_if
// Description : Valid/ready bundle that carries expanded masked S-box terms
//               in and compressed output shares out of masked_sbox_compress.
//               The master side is upstream and downstream combined, and the
//               slave side is the compression stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface masked_sbox_compress_if #(
    parameter int NUM_COORD = 2,
    parameter int CNT_W     = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [9*NUM_COORD-1:0]   in_terms;
    logic [3*NUM_COORD-1:0]   rnd;
    logic                     out_valid;
    logic                     out_ready;
    logic [3*NUM_COORD-1:0]   out_shares;
    logic [CNT_W-1:0]         out_cnt;

    modport master (
        output in_valid, in_terms, rnd, out_ready,
        input  in_ready, out_valid, out_shares, out_cnt
    );

    modport slave (
        input  in_valid, in_terms, rnd, out_ready,
        output in_ready, out_valid, out_shares, out_cnt
    );
endinterface
`default_nettype wire

// File: rtl/masked_sbox_compress.sv
`default_nettype none
// ============================================================================
// Module      : masked_sbox_compress
// Description : 3-share compression stage for the masked PRINCE S-box.
//               Stage 1 registers the 9 cross-share terms of each coordinate
//               with an optional zero-sum refresh. Stage 2 XOR-folds each
//               group of 3 registered terms into one output share.
//               The two-deep valid/ready pipeline supports full backpressure.
//               Optional feature macro: MASK_REFRESH_EN (refresh with rnd).
// Revision    : 1.0 - initial release
// ============================================================================
module masked_sbox_compress #(
    parameter int NUM_COORD = 2,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    masked_sbox_compress_if.slave      bus
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [9*NUM_COORD-1:0] r_z;
    logic [3*NUM_COORD-1:0] r_shares;
    logic                   r_v1;
    logic                   r_v2;
    logic [CNT_W-1:0]       r_cnt;

    logic [9*NUM_COORD-1:0] w_z_next;
    logic [3*NUM_COORD-1:0] w_s_next;
    logic                   w_adv2;
    logic                   w_in_fire;
    logic                   w_out_fire;

    // Stage 2 can take stage 1's content when it is empty or being drained.
    assign w_adv2     = r_v1 & (~r_v2 | bus.out_ready);
    assign bus.in_ready = ~r_v1 | w_adv2;
    assign w_in_fire  = bus.in_valid & bus.in_ready;
    assign w_out_fire = r_v2 & bus.out_ready;

    for (genvar k = 0; k < NUM_COORD; k++) begin : g_coord
        logic [8:0] w_e;
        assign w_e = bus.in_terms[9*k +: 9];

`ifdef MASK_REFRESH_EN
        // Each random bit is used twice, so the masks on terms 0,3,6 cancel
        // in the total XOR while every output share gets fresh randomness.
        logic [2:0] w_r;
        assign w_r = bus.rnd[3*k +: 3];
        assign w_z_next[9*k +: 9] = w_e ^ {2'b00, w_r[2] ^ w_r[0],
                                           2'b00, w_r[1] ^ w_r[2],
                                           2'b00, w_r[0] ^ w_r[1]};
`else
        assign w_z_next[9*k +: 9] = w_e;
`endif

        for (genvar j = 0; j < 3; j++) begin : g_share
            // Fold only registered terms, so glitches never mix shares.
            assign w_s_next[3*k + j] = ^r_z[9*k + 3*j +: 3];
        end
    end

`ifndef MASK_REFRESH_EN
    // rnd stays on the port so both builds share one interface.
    logic unused_rnd;
    assign unused_rnd = ^bus.rnd;
`endif

    // Stage 1: glitch-stopping capture of the (refreshed) expanded terms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_z  <= '0;
            r_v1 <= 1'b0;
        end else begin
            if (w_in_fire) begin
                r_z <= w_z_next;
            end
            r_v1 <= w_in_fire | (r_v1 & ~w_adv2);
        end
    end

    // Stage 2: compressed shares are held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shares <= '0;
            r_v2     <= 1'b0;
        end else begin
            if (w_adv2) begin
                r_shares <= w_s_next;
            end
            r_v2 <= w_adv2 | (r_v2 & ~bus.out_ready);
        end
    end

    // Completed output handshakes, wrapping at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_out_fire) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    assign bus.out_valid  = r_v2;
    assign bus.out_shares = r_shares;
    assign bus.out_cnt    = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_masked_sbox_compress.sv
`default_nettype none
// ============================================================================
// Module      : tb_masked_sbox_compress
// Description : Self-checking bench for masked_sbox_compress (2 coordinates,
//               10-bit counter so that counter wrap is reachable).
//               Honours MASK_REFRESH_EN for its expected share values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_masked_sbox_compress;

    localparam int NC = 2;
    localparam int CW = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    masked_sbox_compress_if #(.NUM_COORD(NC), .CNT_W(CW)) bus();

    masked_sbox_compress #(.NUM_COORD(NC), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] shares;
        logic [1:0] par;
    } exp_t;

    typedef struct {
        logic [17:0] terms;
        logic [5:0]  rnd;
        logic [5:0]  exp;
    } vec_t;

    exp_t       sb[$];
    logic [5:0] cur_exp = '0;
    int         total   = 0;
    int         bad     = 0;
    int         n_items = 0;
    vec_t       tbl[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: refresh masks on terms 0,3,6, then XOR-fold groups of 3.
    function automatic logic [5:0] model(input logic [17:0] t, input logic [5:0] r);
        logic [17:0] z;
        logic [5:0]  s;
        z = t;
`ifdef MASK_REFRESH_EN
        for (int k = 0; k < NC; k++)
            for (int j = 0; j < 3; j++)
                z[9*k + 3*j] = z[9*k + 3*j] ^ r[3*k + j] ^ r[3*k + ((j + 1) % 3)];
`endif
        for (int k = 0; k < NC; k++)
            for (int j = 0; j < 3; j++)
                s[3*k + j] = z[9*k + 3*j] ^ z[9*k + 3*j + 1] ^ z[9*k + 3*j + 2];
        return s;
    endfunction

    // Scoreboard: both handshakes are judged at the falling edge, where
    // inputs (driven 1 time unit after the rising edge) and outputs are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total = total + 1;
                    bad   = bad + 1;
                    $display("FAIL sb_unexpected: got output %0h want none", bus.out_shares);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_shares", 32'(bus.out_shares), 32'(e.shares));
                    check("sb_xor", 32'({^bus.out_shares[5:3], ^bus.out_shares[2:0]}), 32'(e.par));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({cur_exp, ^bus.in_terms[17:9], ^bus.in_terms[8:0]});
                n_items = n_items + 1;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [17:0] t, input logic [5:0] r, input logic [5:0] e);
        bus.in_valid = 1'b1;
        bus.in_terms = t;
        bus.rnd      = r;
        cur_exp      = e;
    endtask

    // Present one item and return 1 unit after the edge that accepted it.
    task automatic send_item(input logic [17:0] t, input logic [5:0] r, input logic [5:0] e);
        bit acc;
        acc = 1'b0;
        drive(t, r, e);
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL send_timeout: got no accept want accept");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) step();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        sb.delete();
        n_items = 0;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [17:0] t;
        logic [5:0]  r;
        int          idx;
        int          gap;
        bit          stream_done;

        // {in_terms, rnd, expected out_shares}
`ifdef MASK_REFRESH_EN
        tbl[0] = '{18'h001FF, 6'b000101, 6'b000100};
        tbl[1] = '{18'h00000, 6'b000001, 6'b000101};
        tbl[2] = '{18'h3FE00, 6'b011000, 6'b001000};
        tbl[3] = '{18'h00000, 6'b111111, 6'b000000};
        tbl[4] = '{18'h00010, 6'b000000, 6'b000010};
        tbl[5] = '{18'h20000, 6'b010010, 6'b111011};
`else
        tbl[0] = '{18'h001FF, 6'b000101, 6'b000111};
        tbl[1] = '{18'h00000, 6'b000001, 6'b000000};
        tbl[2] = '{18'h3FE00, 6'b011000, 6'b111000};
        tbl[3] = '{18'h00000, 6'b111111, 6'b000000};
        tbl[4] = '{18'h00010, 6'b000000, 6'b000010};
        tbl[5] = '{18'h20000, 6'b010010, 6'b100000};
`endif

        // Reset with random activity on every input.
        bus.in_valid  = 1'b1;
        bus.in_terms  = 18'($urandom);
        bus.rnd       = 6'($urandom);
        bus.out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            bus.in_terms  = 18'($urandom);
            bus.rnd       = 6'($urandom);
            bus.out_ready = 1'($urandom);
            step();
        end
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_shares", 32'(bus.out_shares), 32'd0);
        check("rst_out_cnt", 32'(bus.out_cnt), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        step();

        // Single item: latency of two edges from an empty pipeline.
        send_item(tbl[0].terms, tbl[0].rnd, tbl[0].exp);
        check("lat_edge_n", 32'(bus.out_valid), 32'd0);
        step();
        check("lat_edge_n1", 32'(bus.out_valid), 32'd1);
        drain();

        // Vector table, one item at a time.
        for (int i = 0; i < 6; i++) begin
            send_item(tbl[i].terms, tbl[i].rnd, tbl[i].exp);
            drain();
        end
        check("cnt_after_table", 32'(bus.out_cnt), 32'(n_items));

        // Backpressure: 4 items, sink stalled for 5 cycles.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            t = 18'(1) << (3 * idx);
            drive(t, 6'b0, model(t, 6'b0));
            @(negedge clk);
            if (bus.in_ready) idx = idx + 1;
            step();
        end
        check("bp_accepts", 32'(idx), 32'd2);
        check("bp_in_ready_full", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 4; c++) begin
            t = 18'(1) << (3 * idx);
            drive(t, 6'b0, model(t, 6'b0));
            @(negedge clk);
            if (bus.in_ready) idx = idx + 1;
            step();
        end
        bus.in_valid = 1'b0;
        check("bp_all_accepted", 32'(idx), 32'd4);
        drain();
        check("cnt_after_bp", 32'(bus.out_cnt), 32'(n_items));

        // Streaming with random stalls on both sides.
        do_reset();
        stream_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    gap = $urandom_range(0, 2);
                    for (int g = 0; g < gap; g++) step();
                    t = 18'($urandom);
                    r = 6'($urandom);
                    send_item(t, r, model(t, r));
                end
                drain();
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    step();
                end
                bus.out_ready = 1'b1;
            end
        join
        check("stream_cnt", 32'(bus.out_cnt), 32'd1000);

        // 30 more items: the 10-bit counter wraps through 1023 -> 0 -> 6.
        for (int n = 0; n < 30; n++) begin
            t = 18'($urandom);
            r = 6'($urandom);
            send_item(t, r, model(t, r));
        end
        drain();
        check("cnt_wrap", 32'(bus.out_cnt), 32'd6);

        // Mid-operation asynchronous reset with both stages full.
        bus.out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            t = 18'($urandom);
            r = 6'($urandom);
            drive(t, r, model(t, r));
            step();
        end
        bus.in_valid = 1'b0;
        check("mr_full_in_ready", 32'(bus.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid_drop", 32'(bus.out_valid), 32'd0);
        check("mr_out_shares_clr", 32'(bus.out_shares), 32'd0);
        check("mr_out_cnt_clr", 32'(bus.out_cnt), 32'd0);
        check("mr_in_ready", 32'(bus.in_ready), 32'd1);
        sb.delete();
        n_items = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        send_item(tbl[1].terms, tbl[1].rnd, tbl[1].exp);
        check("mr_lat_edge_n", 32'(bus.out_valid), 32'd0);
        step();
        check("mr_lat_edge_n1", 32'(bus.out_valid), 32'd1);
        drain();
        check("mr_cnt", 32'(bus.out_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/masked_sbox_compress.md
# masked_sbox_compress

Second-order (3-share) compression and register stage placed directly downstream of the nonlinear component-function layer of the masked PRINCE S-box. It captures the 9 cross-share terms produced per output coordinate into a glitch-stopping register and applies a zero-sum fresh-randomness refresh. It then XOR-compresses each coordinate's 9 terms back to 3 output shares in a second registered stage. Transfer uses a 2-deep valid/ready pipeline with full backpressure.

## Interface
- `NUM_COORD`, default 2: output coordinates handled per instance. Each coordinate has 9 expanded terms, component-function indices 0–8 and 9–17 respectively.
- `CNT_W`, default 16: width of the output-transfer counter.

- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: expanded terms present.
- `in_ready`  out  1: stage 1 accepts this cycle.
- `in_terms`  in  9*NUM_COORD: term `e[k][i]` sits at bit `9k+i`. Term index `i = 3*j + m`, with share `j` of `d` and share `m` of `c`.
- `rnd`  in  3*NUM_COORD: fresh random bits `r[k][0..2]` at bits `3k..3k+2`. Sampled only on an input handshake.
- `out_valid`  out  1: output shares valid.
- `out_ready`  in  1: downstream accepts.
- `out_shares`  out  3*NUM_COORD: share `s[k][j]` at bit `3k+j`.
- `out_cnt`  out  CNT_W: number of completed output handshakes.

## Operation
- Stage 1 register `z`, holding `9*NUM_COORD` bits, plus flag `v1`. On an input handshake (`in_valid & in_ready`), for every `k`:
  - For `i ∉ {0,3,6}`: `z[k][i] = e[k][i]`.
  - For `j = 0..2`: `z[k][3j] = e[k][3j] ^ r[k][j] ^ r[k][(j+1) mod 3]`.
  - The masks sum to zero, so the XOR over all 9 `z` terms equals the XOR over all 9 `e` terms.
- Stage 2 register `out_shares` plus flag `v2`. On a transfer from stage 1 to stage 2: `s[k][j] = z[k][3j] ^ z[k][3j+1] ^ z[k][3j+2]`.
- No combinational path from `in_terms` or `rnd` to `out_shares`. Both stages are registered so glitches cannot combine shares.
- Handshake and advance rules:
  - `adv2 = v1 & (~v2 | out_ready)`
  - `in_ready = ~v1 | adv2`
  - `v1` next = `(in_valid & in_ready) | (v1 & ~adv2)`
  - `v2` next = `adv2 | (v2 & ~out_ready)`
- Output data is held stable while `out_valid & ~out_ready`. `z` is held while `v1 & ~adv2`.
- `out_cnt` increments by 1 on each `out_valid & out_ready` and wraps modulo `2^CNT_W`.
- Inputs arriving while `in_ready = 0` are ignored. The upstream block must hold its data.

## Timing
- Reset values: `z = 0`, `out_shares = 0`, `v1 = v2 = 0`, `out_valid = 0`, `out_cnt = 0`. `in_ready` reads 1 during and after reset.
- Latency: 2 cycles. An input accepted at edge N gives `out_valid = 1` after edge N+1, when both stages were empty beforehand.
- Throughput: 1 transfer per cycle while `out_ready = 1`.
- Full condition: with `v1 = v2 = 1` and `out_ready = 0`, `in_ready = 0`.
- Simultaneous events:
  - When full and `out_ready` rises, stage 2 accepts `z` and stage 1 accepts a new input on the same edge.
  - `in_ready` may depend combinationally on `out_ready`. This is the only combinational input-to-output path.
- Reset asserted mid-operation immediately clears both valid flags and all data, with no handshake. In-flight items are dropped.
- `out_cnt` wraps from `2^CNT_W - 1` to 0 on the next handshake.

## Configuration
- `MASK_REFRESH_EN` defined: refresh applied as above. `rnd` is consumed.
- `MASK_REFRESH_EN` undefined: `z[k][i] = e[k][i]` for all `i`. The `rnd` port remains but is unused. Functional XOR of the outputs is identical; first-order-only security is acceptable for area builds.

## Test plan
- Reset check: hold `rst_n = 0` with random inputs. Required response: `out_valid = 0`, `out_shares = 0`, `out_cnt = 0`, `in_ready = 1`.
- Single item:
  - Stimulus: `in_terms = 18'h0_01FF` (coordinate 0 all ones, coordinate 1 zeros), `rnd = 6'b000_101`, `out_ready = 1`.
  - Required response: `out_valid` rises 2 cycles later. `s[0] = {1, 0, 0}` gives XOR 1. Coordinate 1 shares XOR to 0.
- Refresh check:
  - Stimulus: `in_terms = 0`, `rnd[0..2] = 3'b001`.
  - Required response: `s[0] = {1, 0, 1}` gives XOR 0, with refresh enabled. With the macro undefined, `s[0] = {0, 0, 0}`.
- Backpressure:
  - Stimulus: stream 4 items with `out_ready = 0` for 5 cycles.
  - Required response: `in_ready = 0` after 2 accepts. Once released, all 4 items are delivered in order, with no loss or duplication.
- Streaming: 1000 random items with random stalls on both sides. Required response: for every item and coordinate, output-share XOR equals input-term XOR, and `out_cnt = 1000`.
- Mid-operation reset: with both stages full, pulse `rst_n = 0` for 1 cycle asynchronously. Required response: `out_valid` drops immediately, and the first new item appears 2 cycles after acceptance.
